// File: rtl/timestamp_pkg.sv
// Shared definitions for the timestamp readout path: word layout, type
// nibble codes and the arbiter FSM state encoding.
package timestamp_pkg;

    localparam int TS_WORD_W   = 32;
    localparam int TS_TYPE_LSB = 24;
    localparam int TS_TYPE_MSB = 27;

    localparam logic [3:0] TS_TYPE_LOW  = 4'h1;
    localparam logic [3:0] TS_TYPE_MID  = 4'h2;
    localparam logic [3:0] TS_TYPE_HIGH = 4'h3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Extract the word-type nibble of a timestamp word.
    function automatic logic [3:0] ts_type(input logic [TS_WORD_W-1:0] w);
        return w[TS_TYPE_MSB:TS_TYPE_LSB];
    endfunction

endpackage

// File: rtl/timestamp_stream_arbiter_if.sv
// Bus bundle of the timestamp stream arbiter: N first-word-fall-through
// input FIFOs on one side, a single FWFT-style output on the other.
// slave = arbiter side, master = environment (FIFOs and downstream sink).
interface timestamp_stream_arbiter_if
    import timestamp_pkg::*;
#(
    parameter int N = 4
);
    logic [N-1:0]           IN_EMPTY;
    logic [TS_WORD_W*N-1:0] IN_DATA;
    logic [N-1:0]           IN_READ;
    logic                   OUT_READ;
    logic                   OUT_EMPTY;
    logic [TS_WORD_W-1:0]   OUT_DATA;
    logic [N-1:0]           GRANT;
    logic [7:0]             FRAME_ERR_CNT;

    modport slave (
        input  IN_EMPTY, IN_DATA, OUT_READ,
        output IN_READ, OUT_EMPTY, OUT_DATA, GRANT, FRAME_ERR_CNT
    );

    modport master (
        output IN_EMPTY, IN_DATA, OUT_READ,
        input  IN_READ, OUT_EMPTY, OUT_DATA, GRANT, FRAME_ERR_CNT
    );
endinterface

// File: rtl/timestamp_stream_arbiter_rr_select.sv
// Combinational round-robin picker: returns the first requesting input
// searching upward from (ptr_i + 1) mod N, as one-hot and as an index.
module timestamp_stream_arbiter_rr_select #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] idx_o
);

    logic [PTR_W-1:0] cand;

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        for (int off = N; off >= 1; off--) begin
            cand = PTR_W'((int'(ptr_i) + off) % N);
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/timestamp_stream_arbiter.sv
// Round-robin merge of N timestamp word streams into one output stream.
// A grant is held for a whole 3-word timestamp group so groups never
// interleave. Optional frame checking is enabled by defining
// TIMESTAMP_STREAM_ARBITER_FRAME_CHECK_EN; otherwise FRAME_ERR_CNT is 0.
module timestamp_stream_arbiter
    import timestamp_pkg::*;
#(
    parameter int         N         = 4,
    parameter int         GROUP_LEN = 3,
    parameter logic [3:0] LAST_TYPE = TS_TYPE_HIGH
) (
    input  logic                         BUS_CLK,
    input  logic                         RST,
    timestamp_stream_arbiter_if.slave    bus
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(GROUP_LEN + 1);

    arb_state_e           state_q, state_d;
    logic [N-1:0]         grant_q, grant_d;
    logic [PTR_W-1:0]     gidx_q, gidx_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [N-1:0]         pick_gnt;
    logic [PTR_W-1:0]     pick_idx;
    logic [TS_WORD_W-1:0] sel_data;
    logic                 sel_empty;
    logic                 busy;
    logic                 pop;
    logic [3:0]           pop_type;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 group_done;

    timestamp_stream_arbiter_rr_select #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_rr_select (
        .req_i (~bus.IN_EMPTY),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // Route the granted input through to the output (one-hot mux).
    always_comb begin
        sel_data  = '0;
        sel_empty = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                sel_data  = bus.IN_DATA[TS_WORD_W*i +: TS_WORD_W];
                sel_empty = bus.IN_EMPTY[i];
            end
        end
    end

    // RST drops the grant at once, so nothing is popped in the reset cycle.
    assign busy       = (state_q == BUSY) && !RST;
    assign pop        = busy && !sel_empty && bus.OUT_READ;
    assign pop_type   = ts_type(sel_data);
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign group_done = pop && ((pop_type == LAST_TYPE) || (cnt_inc == CNT_W'(GROUP_LEN)));

    assign bus.OUT_EMPTY = busy ? sel_empty : 1'b1;
    assign bus.OUT_DATA  = busy ? sel_data : '0;
    assign bus.IN_READ   = pop ? grant_q : '0;
    assign bus.GRANT     = grant_q;

    // Next-state: pick an owner when idle, count pops and release on group end.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|(~bus.IN_EMPTY)) begin
                    grant_d = pick_gnt;
                    gidx_d  = pick_idx;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (pop) begin
                    cnt_d = cnt_inc;
                end
                if (group_done) begin
                    state_d = IDLE;
                    ptr_d   = gidx_q;
                    grant_d = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= PTR_W'(N - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef TIMESTAMP_STREAM_ARBITER_FRAME_CHECK_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_seen_q, err_seen_d;
    logic       bad_type;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Pop k of a grant must carry type k+1; flag at most once per group.
    always_comb begin
        bad_type   = (pop_type != (4'(cnt_q) + TS_TYPE_LOW));
        err_cnt_d  = err_cnt_q;
        err_seen_d = err_seen_q;
        if (state_q == IDLE) begin
            err_seen_d = 1'b0;
        end else if (pop && bad_type && !err_seen_q) begin
            err_cnt_d  = sat_inc8(err_cnt_q);
            err_seen_d = 1'b1;
        end
    end

    // Misframe counter register.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            err_cnt_q  <= '0;
            err_seen_q <= 1'b0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            err_seen_q <= err_seen_d;
        end
    end

    assign bus.FRAME_ERR_CNT = err_cnt_q;
`else
    assign bus.FRAME_ERR_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_timestamp_stream_arbiter.sv
// Randomised scoreboard bench for timestamp_stream_arbiter. Per-input word
// queues form the reference; a monitor checks ordering, grouping, grant
// order, idle gaps and the misframe count derived from the group rules.
`timescale 1ns/1ps
module tb_timestamp_stream_arbiter;
    import timestamp_pkg::*;

    localparam int N  = 4;
    localparam int GL = 3;

    logic BUS_CLK = 1'b0;
    logic RST     = 1'b1;
    always #5 BUS_CLK = ~BUS_CLK;

    timestamp_stream_arbiter_if #(.N(N)) bus ();

    timestamp_stream_arbiter #(
        .N         (N),
        .GROUP_LEN (GL),
        .LAST_TYPE (TS_TYPE_HIGH)
    ) dut (
        .BUS_CLK (BUS_CLK),
        .RST     (RST),
        .bus     (bus)
    );

    logic [31:0] fq    [N][$];   // contents of the modelled input FIFOs
    logic [31:0] exp_q [N][$];   // words still expected out, per input
    int          own_q [$];      // expected owner of each upcoming group
    int errors    = 0;
    int checks    = 0;
    int xfers     = 0;
    int model_err = 0;
    int grp_cnt   = 0;
    int grp_owner = -1;
    bit grp_bad   = 1'b0;
    bit gap_chk   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int exp_err();
`ifdef TIMESTAMP_STREAM_ARBITER_FRAME_CHECK_EN
        return model_err;
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] mkw(input logic [3:0] ty, input logic [23:0] pl);
        return {4'h0, ty, pl};
    endfunction

    task automatic push(input int i, input logic [31:0] w);
        fq[i].push_back(w);
        exp_q[i].push_back(w);
    endtask

    task automatic tick();
        @(posedge BUS_CLK);
        #1;
    endtask

    // Input FIFO model: present head words after each edge, pop on IN_READ.
    initial begin
        bus.IN_EMPTY = '1;
        bus.IN_DATA  = '0;
        forever begin
            @(posedge BUS_CLK);
            #2;
            for (int i = 0; i < N; i++) begin
                bus.IN_EMPTY[i] = (fq[i].size() == 0);
                bus.IN_DATA[32*i +: 32] = (fq[i].size() != 0) ? fq[i][0] : (32'hDEAD0000 | 32'(i));
            end
            #2;
            for (int i = 0; i < N; i++)
                if (bus.IN_READ[i] && fq[i].size() != 0) void'(fq[i].pop_front());
        end
    end

    // Monitor: compare every forwarded word against the scoreboard.
    initial begin
        logic       xfer;
        int         owner;
        logic [3:0] ty;
        forever begin
            @(posedge BUS_CLK);
            #5;
            if (RST) begin
                grp_cnt   = 0;
                model_err = 0;
                gap_chk   = 1'b0;
                grp_bad   = 1'b0;
            end else begin
                if (gap_chk) begin
                    chk("idle_gap_grant", 32'(bus.GRANT), 32'h0);
                    gap_chk = 1'b0;
                end
                xfer = !bus.OUT_EMPTY && bus.OUT_READ;
                chk("in_read", 32'(bus.IN_READ), xfer ? 32'(bus.GRANT) : 32'h0);
                if (xfer) begin
                    owner = -1;
                    for (int i = 0; i < N; i++) if (bus.GRANT[i]) owner = i;
                    chk("grant_onehot", 32'($countones(bus.GRANT)), 32'd1);
                    if (owner < 0) owner = 0;
                    if (grp_cnt == 0) begin
                        grp_owner = owner;
                        grp_bad   = 1'b0;
                        if (own_q.size() != 0) chk("group_owner", 32'(owner), 32'(own_q.pop_front()));
                    end else begin
                        chk("interleave", 32'(owner), 32'(grp_owner));
                    end
                    if (exp_q[owner].size() == 0) chk("unexpected_word", bus.OUT_DATA, 32'hFFFFFFFF);
                    else chk("data", bus.OUT_DATA, exp_q[owner].pop_front());
                    ty = bus.OUT_DATA[TS_TYPE_MSB:TS_TYPE_LSB];
                    if (int'(ty) != grp_cnt + 1) grp_bad = 1'b1;
                    grp_cnt++;
                    xfers++;
                    if (ty == TS_TYPE_HIGH || grp_cnt == GL) begin
                        if (grp_bad && model_err < 255) model_err++;
                        grp_cnt = 0;
                        gap_chk = 1'b1;
                    end
                end
            end
        end
    end

    task automatic drain(input string name, input int budget);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        bus.OUT_READ = 1'b1;
        while (!done && n < budget) begin
            tick();
            n++;
            done = (bus.GRANT == '0) && (grp_cnt == 0);
            for (int i = 0; i < N; i++)
                if (fq[i].size() != 0 || exp_q[i].size() != 0) done = 1'b0;
        end
        if (!done) chk({name, "_drain_timeout"}, 32'(n), 32'(budget + 1));
        tick();
        tick();
    endtask

    task automatic push_rand_group(input int i);
        int         len;
        logic [3:0] ty;
        if ($urandom_range(0, 1) == 0) begin
            push(i, mkw(TS_TYPE_LOW,  24'($urandom)));
            push(i, mkw(TS_TYPE_MID,  24'($urandom)));
            push(i, mkw(TS_TYPE_HIGH, 24'($urandom)));
        end else begin
            len = $urandom_range(1, GL);
            for (int k = 0; k < len; k++) begin
                if (k == len - 1 && len < GL) ty = TS_TYPE_HIGH;
                else if (k == len - 1) ty = 4'($urandom);
                else begin
                    ty = 4'($urandom);
                    if (ty == TS_TYPE_HIGH) ty = 4'hA;
                end
                push(i, mkw(ty, 24'($urandom)));
            end
        end
    endtask

    initial begin
        int n;
        int cyc;
        int base;
        bus.OUT_READ = 1'b0;
        RST = 1'b1;

        // Reset state
        tick(); tick(); tick();
        #3;
        chk("rst_grant",     32'(bus.GRANT), 32'h0);
        chk("rst_out_empty", 32'(bus.OUT_EMPTY), 32'h1);
        chk("rst_in_read",   32'(bus.IN_READ), 32'h0);
        chk("rst_out_data",  bus.OUT_DATA, 32'h0);
        chk("rst_frame_err", 32'(bus.FRAME_ERR_CNT), 32'h0);
        tick();
        RST = 1'b0;
        tick();

        // Single input, one well-formed group on input 2
        bus.OUT_READ = 1'b1;
        own_q.push_back(2);
        push(2, mkw(TS_TYPE_LOW,  24'h000ABC));
        push(2, mkw(TS_TYPE_MID,  24'h000001));
        push(2, mkw(TS_TYPE_HIGH, 24'h000000));
        n = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.GRANT == 4'b0100) n++;
        end
        chk("single_grant_cycles", 32'(n), 32'd3);
        drain("single", 50);

        // All inputs preloaded with two groups each: strict rotation
        RST = 1'b1;
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < N; i++) begin
                own_q.push_back(i);
                push(i, mkw(TS_TYPE_LOW,  24'(16*g + i)));
                push(i, mkw(TS_TYPE_MID,  24'(16*g + i)));
                push(i, mkw(TS_TYPE_HIGH, 24'(16*g + i)));
            end
        tick(); tick();
        RST  = 1'b0;
        base = xfers;
        cyc  = 0;
        while (xfers < base + 2*N*GL && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("fair_cycles", 32'(cyc), 32'(2*N*(GL+1)));
        drain("fair", 50);

        // Backpressure on input 1
        own_q.push_back(1);
        push(1, mkw(TS_TYPE_LOW,  24'h111111));
        push(1, mkw(TS_TYPE_MID,  24'h222222));
        push(1, mkw(TS_TYPE_HIGH, 24'h333333));
        for (int c = 0; c < 12; c++) begin
            bus.OUT_READ = c[0];
            tick();
        end
        drain("backpressure", 50);

        // Owner underflow: input 3 stalls mid-group while input 0 waits
        bus.OUT_READ = 1'b1;
        own_q.push_back(3);
        own_q.push_back(0);
        push(3, mkw(TS_TYPE_LOW, 24'h0A0A0A));
        push(3, mkw(TS_TYPE_MID, 24'h0B0B0B));
        n = 0;
        while (bus.GRANT != 4'b1000 && n < 20) begin
            tick();
            n++;
        end
        push(0, mkw(TS_TYPE_LOW,  24'h00C001));
        push(0, mkw(TS_TYPE_MID,  24'h00C002));
        push(0, mkw(TS_TYPE_HIGH, 24'h00C003));
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("hold_grant", 32'(bus.GRANT), 32'h8);
        end
        push(3, mkw(TS_TYPE_HIGH, 24'h0C0C0C));
        drain("underflow", 50);

        // Reset after the first pop of a group on input 0
        own_q.push_back(0);
        own_q.push_back(0);
        push(0, mkw(TS_TYPE_LOW,  24'h00D001));
        push(0, mkw(TS_TYPE_MID,  24'h00D002));
        push(0, mkw(TS_TYPE_HIGH, 24'h00D003));
        n = 0;
        while (fq[0].size() != 2 && n < 20) begin
            tick();
            n++;
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #3;
        chk("midrst_grant",     32'(bus.GRANT), 32'h0);
        chk("midrst_out_empty", 32'(bus.OUT_EMPTY), 32'h1);
        drain("midrst", 50);
        chk("midrst_frame_err", 32'(bus.FRAME_ERR_CNT), 32'(exp_err()));

        // 300 misframed groups saturate the counter
        for (int g = 0; g < 300; g++) begin
            push(2, mkw(TS_TYPE_MID,  24'(g)));
            push(2, mkw(TS_TYPE_HIGH, 24'(g)));
        end
        drain("saturate", 2000);
        chk("saturate_frame_err", 32'(bus.FRAME_ERR_CNT), 32'(exp_err()));

        // Randomised traffic with random downstream backpressure
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) push_rand_group($urandom_range(0, N-1));
            bus.OUT_READ = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain("random", 4000);
        chk("random_frame_err", 32'(bus.FRAME_ERR_CNT), 32'(exp_err()));
        chk("owner_queue_empty", 32'(own_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
